// File: rtl/ar_mux41_scanner_if.sv
// Signal bundle between the scanner, its external 4:1 mux and the downstream word consumer.
// The master drives the control inputs and the mux output y_in; the scanner (slave) drives select/enable and the word.
interface ar_mux41_scanner_if;
    logic       en;
    logic       start;
    logic       continuous;
    logic       y_in;
    logic [1:0] sel_out;
    logic       mux_en;
    logic       busy;
    logic [3:0] data_out;
    logic       data_valid;

    modport master (
        output en, start, continuous, y_in,
        input  sel_out, mux_en, busy, data_out, data_valid
    );

    modport slave (
        input  en, start, continuous, y_in,
        output sel_out, mux_en, busy, data_out, data_valid
    );
endinterface

// File: rtl/ar_mux41_scanner.sv
// Steps a 4:1 mux select 0..3, samples y_in after SETTLE idle cycles per select, and emits the 4-bit word with a 1-cycle strobe.
// Word latency is 4*(SETTLE+1) cycles from start; no backpressure, so the consumer must take data_out on the data_valid cycle.
module ar_mux41_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input logic               clk,
    input logic               rst_n,
    ar_mux41_scanner_if.slave bus
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [1:0] sel_q;
    logic [2:0] shadow_q;
    logic [3:0] data_q;
    logic       data_valid_q;
    logic       mux_en_q;
    logic       busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            sel_q        <= 2'd0;
            shadow_q     <= 3'd0;
            data_q       <= 4'd0;
            data_valid_q <= 1'b0;
            mux_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.en && bus.start) begin
                        state_q  <= ST_SETTLE;
                        sel_q    <= 2'd0;
                        mux_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= SETTLE_C;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.en) begin
                        // Abort: partial word is dropped, last completed word is kept.
                        state_q  <= ST_IDLE;
                        sel_q    <= 2'd0;
                        mux_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        shadow_q <= 3'd0;
                        cnt_q    <= 8'd0;
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (sel_q != 2'd3) begin
                        shadow_q[sel_q] <= bus.y_in;
                        sel_q           <= sel_q + 2'd1;
                        cnt_q           <= SETTLE_C;
                    end else begin
                        data_q       <= {bus.y_in, shadow_q};
                        data_valid_q <= 1'b1;
                        sel_q        <= 2'd0;
                        cnt_q        <= SETTLE_C;
                        if (!bus.continuous) begin
                            state_q  <= ST_IDLE;
                            mux_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            cnt_q    <= 8'd0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.sel_out    = sel_q;
    assign bus.mux_en     = mux_en_q;
    assign bus.busy       = busy_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_ar_mux41_scanner.sv
// Directed bench: three scanner instances (SETTLE = 1, 0, 255), each reading a behavioural 4:1 mux.
module tb_ar_mux41_scanner;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] a1, a0, a255;

    ar_mux41_scanner_if ifc1 ();
    ar_mux41_scanner_if ifc0 ();
    ar_mux41_scanner_if ifc255 ();

    assign ifc1.y_in   = ifc1.mux_en   ? a1[ifc1.sel_out]     : 1'b0;
    assign ifc0.y_in   = ifc0.mux_en   ? a0[ifc0.sel_out]     : 1'b0;
    assign ifc255.y_in = ifc255.mux_en ? a255[ifc255.sel_out] : 1'b0;

    ar_mux41_scanner #(.SETTLE(1))   u_s1   (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
    ar_mux41_scanner #(.SETTLE(0))   u_s0   (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
    ar_mux41_scanner #(.SETTLE(255)) u_s255 (.clk(clk), .rst_n(rst_n), .bus(ifc255.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_sel [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        int dv_cnt;

        rst_n = 1'b0;
        a1 = 4'b0101; a0 = 4'b1010; a255 = 4'b1001;
        ifc1.en = 1'b1; ifc1.start = 1'b1; ifc1.continuous = 1'b0;
        ifc0.en = 1'b0; ifc0.start = 1'b0; ifc0.continuous = 1'b0;
        ifc255.en = 1'b0; ifc255.start = 1'b0; ifc255.continuous = 1'b0;

        // Reset held with start/en high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", 32'(ifc1.busy), 32'd0);
            check("rst_mux_en", 32'(ifc1.mux_en), 32'd0);
            check("rst_sel", 32'(ifc1.sel_out), 32'd0);
            check("rst_data", 32'(ifc1.data_out), 32'd0);
            check("rst_dv", 32'(ifc1.data_valid), 32'd0);
        end

        // Release: scan starts at the next edge (edge 0); then a single scan of 0101
        rst_n = 1'b1;
        tick();
        check("start_busy", 32'(ifc1.busy), 32'd1);
        check("start_mux_en", 32'(ifc1.mux_en), 32'd1);
        ifc1.start = 1'b0;
        for (int e = 0; e < 8; e++) begin
            check("single_sel", 32'(ifc1.sel_out), 32'(exp_sel[e]));
            check("single_dv_low", 32'(ifc1.data_valid), 32'd0);
            tick();
        end
        check("single_dv", 32'(ifc1.data_valid), 32'd1);
        check("single_data", 32'(ifc1.data_out), 32'h5);
        check("single_busy_end", 32'(ifc1.busy), 32'd0);
        check("single_mux_en_end", 32'(ifc1.mux_en), 32'd0);
        tick();
        check("single_dv_once", 32'(ifc1.data_valid), 32'd0);
        check("single_data_hold", 32'(ifc1.data_out), 32'h5);

        // Abort after the sel=2 capture (edge 6) of a 1111 scan
        a1 = 4'b1111;
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("abort_pre_sel", 32'(ifc1.sel_out), 32'd3);
        ifc1.en = 1'b0;
        tick();
        check("abort_busy", 32'(ifc1.busy), 32'd0);
        check("abort_mux_en", 32'(ifc1.mux_en), 32'd0);
        check("abort_sel", 32'(ifc1.sel_out), 32'd0);
        check("abort_dv", 32'(ifc1.data_valid), 32'd0);
        check("abort_data", 32'(ifc1.data_out), 32'h5);
        tick();
        check("abort_dv2", 32'(ifc1.data_valid), 32'd0);
        ifc1.en = 1'b1;

        // Start pulsed repeatedly during a scan of 0110: exactly one word
        a1 = 4'b0110;
        ifc1.start = 1'b1;
        tick();
        dv_cnt = 0;
        for (int e = 1; e <= 16; e++) begin
            ifc1.start = (e <= 6) ? e[0] : 1'b0;
            tick();
            if (ifc1.data_valid) begin
                dv_cnt++;
                check("ign_data", 32'(ifc1.data_out), 32'h6);
            end
        end
        ifc1.start = 1'b0;
        check("ign_dv_count", 32'(dv_cnt), 32'd1);

        // Reset mid-scan with sel_out=1
        ifc1.start = 1'b1;
        tick();
        ifc1.start = 1'b0;
        tick(); tick();
        check("midrst_pre_sel", 32'(ifc1.sel_out), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(ifc1.busy), 32'd0);
        check("midrst_mux_en", 32'(ifc1.mux_en), 32'd0);
        check("midrst_sel", 32'(ifc1.sel_out), 32'd0);
        check("midrst_data", 32'(ifc1.data_out), 32'd0);
        check("midrst_dv", 32'(ifc1.data_valid), 32'd0);
        rst_n = 1'b1;
        ifc1.en = 1'b0;
        tick();

        // Continuous, SETTLE=0: words 1010, 0010 (a changes after edge 5), 0011
        a0 = 4'b1010;
        ifc0.en = 1'b1; ifc0.continuous = 1'b1; ifc0.start = 1'b1;
        tick();
        ifc0.start = 1'b0;
        check("cont_sel0", 32'(ifc0.sel_out), 32'd0);
        for (int e = 1; e <= 13; e++) begin
            tick();
            check("cont_dv", 32'(ifc0.data_valid), 32'((e % 4) == 0));
            if (e == 4) begin
                check("cont_w1", 32'(ifc0.data_out), 32'hA);
                check("cont_busy_w1", 32'(ifc0.busy), 32'd1);
                check("cont_sel_wrap", 32'(ifc0.sel_out), 32'd0);
            end
            if (e == 5) a0 = 4'b0011;
            if (e == 8) check("cont_w2", 32'(ifc0.data_out), 32'h2);
            if (e == 10) ifc0.continuous = 1'b0;
            if (e == 12) begin
                check("cont_w3", 32'(ifc0.data_out), 32'h3);
                check("cont_busy_end", 32'(ifc0.busy), 32'd0);
            end
        end
        check("cont_idle_busy", 32'(ifc0.busy), 32'd0);
        ifc0.en = 1'b0;

        // SETTLE=255 scan of 1001
        ifc255.en = 1'b1; ifc255.start = 1'b1;
        tick();
        ifc255.start = 1'b0;
        check("s255_sel_e0", 32'(ifc255.sel_out), 32'd0);
        check("s255_busy", 32'(ifc255.busy), 32'd1);
        dv_cnt = 0;
        for (int e = 1; e <= 1024; e++) begin
            tick();
            if (ifc255.data_valid) dv_cnt++;
            if (e == 255)  check("s255_sel_255", 32'(ifc255.sel_out), 32'd0);
            if (e == 256)  check("s255_sel_256", 32'(ifc255.sel_out), 32'd1);
            if (e == 511)  check("s255_sel_511", 32'(ifc255.sel_out), 32'd1);
            if (e == 512)  check("s255_sel_512", 32'(ifc255.sel_out), 32'd2);
            if (e == 767)  check("s255_sel_767", 32'(ifc255.sel_out), 32'd2);
            if (e == 768)  check("s255_sel_768", 32'(ifc255.sel_out), 32'd3);
            if (e == 1023) check("s255_sel_1023", 32'(ifc255.sel_out), 32'd3);
            if (e == 1024) begin
                check("s255_dv", 32'(ifc255.data_valid), 32'd1);
                check("s255_data", 32'(ifc255.data_out), 32'h9);
                check("s255_busy_end", 32'(ifc255.busy), 32'd0);
            end
        end
        check("s255_dv_count", 32'(dv_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ar_mux41_scanner.md
Name: ar_mux41_scanner

Overview:
- Reader end of the 4:1 mux interface: drives the select and enable lines of an external 4:1 mux (a[3:0], sel[1:0], enable -> y).
- Steps sel through 0..3 and samples y after a programmable settle time.
- Reassembles the four sampled bits into a parallel 4-bit word, delivered with a one-cycle valid strobe.
- Sits between the mux (or any single-line selectable source) and downstream logic that needs a[3:0] back in parallel.

Parameters:
- SETTLE, 1, idle cycles after each sel change before y is sampled; legal range 0..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  block enable; low aborts any scan in progress.
- start  input  1  request one scan; sampled only in IDLE.
- continuous  input  1  when high at end of a scan, the next scan starts immediately.
- y_in  input  1  mux output being sampled.
- sel_out  output  2  select driven to the mux (mux sel).
- mux_en  output  1  enable driven to the mux; high only while scanning.
- busy  output  1  high while a scan is in progress.
- data_out  output  4  last completed word; bit i = y sampled with sel_out = i.
- data_valid  output  1  one-cycle strobe; data_out updated in the same cycle.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, sel_out=0, mux_en=0, busy=0, data_out=0, data_valid=0, shadow=0, settle counter=0.
  - Reset wins over every other input, including mid-scan.
- States: IDLE, SETTLE.
- IDLE:
  - en=1 and start=1 at an edge -> sel_out=0, mux_en=1, busy=1, cnt=SETTLE, go to SETTLE.
  - Otherwise hold. start with en=0 is ignored.
- SETTLE, each edge:
  - en=0 -> go to IDLE, mux_en=0, busy=0, sel_out=0, shadow discarded, data_out unchanged, no data_valid.
  - cnt!=0 -> cnt-1.
  - cnt==0 -> capture: shadow[sel_out] = y_in.
    - If sel_out<3: sel_out+1, cnt=SETTLE.
    - If sel_out==3: data_out = {y_in, shadow[2:0]}, data_valid=1 for exactly one cycle, then:
      - continuous=1 and en=1: sel_out=0, cnt=SETTLE, stay in SETTLE with busy=1.
      - otherwise: go to IDLE, mux_en=0, busy=0, sel_out=0.
- Timing: with start sampled at edge 0, captures occur at edges k*(SETTLE+1) for k=1..4. data_valid is high during the cycle after edge 4*(SETTLE+1). For SETTLE=1 that is after edge 8, and sel_out changes every 2 cycles.
- Continuous mode: no gap between words. data_valid recurs every 4*(SETTLE+1) cycles.
- start asserted while busy=1 is ignored, with no queuing. A start level held high in IDLE after a finished scan begins a new scan at the next edge.
- sel_out wraps 3 -> 0 only at scan boundaries; it never counts past 3.
- data_out holds its value between strobes and across aborts. Only reset clears it.
- y_in may change at any time. Only its value at the capture edge matters.
- Counter width is 8 bits. SETTLE=0 means the capture happens at the first edge after a sel change.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with start=1 and en=1 -> all outputs 0, busy stays 0. Release -> scan begins at the next edge.
- Single scan, SETTLE=1, behavioral mux with a=4'b0101, en=1, start pulsed 1 cycle:
  - sel_out sequence 0,0,1,1,2,2,3,3.
  - data_valid high exactly 1 cycle after edge 8 with data_out=4'b0101.
  - busy and mux_en then drop to 0.
- Continuous, SETTLE=0:
  - a=4'b1010 then changed to 4'b0011 mid-second-word, continuous=1.
  - data_valid every 4 cycles; first word 1010.
  - Second word mixes bits per capture edge, as checked by the reference model.
  - continuous=0 before the third word ends -> return to IDLE after the third strobe.
- Abort: drop en after the capture with sel_out=2 in a scan of a=4'b1111 -> next edge IDLE, busy=0, no data_valid, data_out retains its previous value (0101).
- Ignored start: pulse start repeatedly during a scan -> exactly one data_valid. Reset mid-scan (sel_out=1) -> all outputs 0 at the next edge.
- SETTLE=255: a=4'b1001 -> data_valid after edge 1024, data_out=1001. sel_out holds each value for 256 cycles.
